// File: rtl/text_grid_writer_if.sv
// Write handshake, cursor status and beam-indexed read port of the text grid writer.
// The producer/renderer side uses the master modport; the grid writer uses slave.
interface text_grid_writer_if #(
  parameter int COLS = 20,
  parameter int ROWS = 15
);
  logic [7:0]              wr_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic                    busy;
  logic [$clog2(ROWS)-1:0] cursor_row;
  logic [$clog2(COLS)-1:0] cursor_col;
  logic [9:0]              VGA_row;
  logic [9:0]              VGA_col;
  logic [7:0]              rd_char;
  logic                    rd_in_grid;

  modport master (
    output wr_data, wr_valid, VGA_row, VGA_col,
    input  wr_ready, busy, cursor_row, cursor_col, rd_char, rd_in_grid
  );

  modport slave (
    input  wr_data, wr_valid, VGA_row, VGA_col,
    output wr_ready, busy, cursor_row, cursor_col, rd_char, rd_in_grid
  );
endinterface

// File: rtl/text_grid_writer.sv
// Character-grid text buffer: ASCII byte stream in, cursor handling, beam-indexed char out.
// Define TEXT_GRID_WRITER_SCROLL_EN to scroll at the bottom row instead of wrapping to row 0.
module text_grid_writer #(
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int SCALE      = 4,
  parameter int ORIGIN_ROW = 0,
  parameter int ORIGIN_COL = 0
) (
  input  logic              clk,
  input  logic              rst_l,
  text_grid_writer_if.slave bus
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int SH    = $clog2(8 * SCALE);
  localparam logic [9:0] ORG_R  = 10'(ORIGIN_ROW);
  localparam logic [9:0] ORG_C  = 10'(ORIGIN_COL);
  localparam logic [9:0] ROWS_V = 10'(ROWS);
  localparam logic [9:0] COLS_V = 10'(COLS);
  localparam logic [7:0] SPACE  = 8'h20;

`ifdef TEXT_GRID_WRITER_SCROLL_EN
  typedef enum logic [1:0] {CLEAR, READY, ROWCLR} state_e;
`else
  typedef enum logic [1:0] {CLEAR, READY} state_e;
`endif

  function automatic logic [AW-1:0] cell_addr(input int prow, input int col);
    return AW'(prow * COLS + col);
  endfunction

  function automatic int wrap_row(input int r);
    return (r >= ROWS) ? r - ROWS : r;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] base_q, base_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    rd_char_q;
  logic          rd_in_grid_q;

  logic [7:0]    mem [CELLS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          row_adv;
  logic [AW-1:0] cur_addr;

  // Logical rows are offset by base so a scroll only rewrites one physical row.
  assign cur_addr = cell_addr(wrap_row(int'(row_q) + int'(base_q)), int'(col_q));

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    row_d   = row_q;
    col_d   = col_q;
    base_d  = base_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = SPACE;
    row_adv = 1'b0;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = sweep_q;
        if (sweep_q == AW'(CELLS - 1)) begin
          state_d = READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      READY: begin
        if (bus.wr_valid) begin
          if (bus.wr_data >= 8'h20 && bus.wr_data <= 8'h7E) begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = bus.wr_data;
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              row_adv = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (bus.wr_data == 8'h0A) begin
            col_d   = '0;
            row_adv = 1'b1;
          end else if (bus.wr_data == 8'h0C) begin
            row_d   = '0;
            col_d   = '0;
            base_d  = '0;
            sweep_d = '0;
            state_d = CLEAR;
          end
          if (row_adv) begin
            if (row_q != RW'(ROWS - 1)) begin
              row_d = row_q + 1'b1;
            end else begin
`ifdef TEXT_GRID_WRITER_SCROLL_EN
              base_d  = (base_q == RW'(ROWS - 1)) ? '0 : base_q + 1'b1;
              sweep_d = '0;
              state_d = ROWCLR;
`else
              row_d = '0;
`endif
            end
          end
        end
      end
`ifdef TEXT_GRID_WRITER_SCROLL_EN
      // base_q has already moved on, so the new bottom row is physical base_q-1.
      ROWCLR: begin
        we    = 1'b1;
        waddr = cell_addr((base_q == '0) ? ROWS - 1 : int'(base_q) - 1, int'(sweep_q));
        if (sweep_q == AW'(COLS - 1)) begin
          state_d = READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
`endif
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [9:0]    rel_r, rel_c, cell_r, cell_c;
  logic          in_grid;
  logic [AW-1:0] rd_addr;

  // Unsigned subtraction: a beam above/left of the origin fails the >= tests.
  always_comb begin
    rel_r   = bus.VGA_row - ORG_R;
    rel_c   = bus.VGA_col - ORG_C;
    cell_r  = rel_r >> SH;
    cell_c  = rel_c >> SH;
    in_grid = (bus.VGA_row >= ORG_R) && (bus.VGA_col >= ORG_C) &&
              (cell_r < ROWS_V) && (cell_c < COLS_V);
    rd_addr = in_grid ? cell_addr(wrap_row(int'(cell_r) + int'(base_q)), int'(cell_c)) : '0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_char_q    <= SPACE;
      rd_in_grid_q <= 1'b0;
    end else begin
      rd_char_q    <= in_grid ? mem[rd_addr] : SPACE;
      rd_in_grid_q <= in_grid;
    end
  end

  assign bus.wr_ready   = (state_q == READY);
  assign bus.busy       = (state_q != READY);
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
  assign bus.rd_char    = rd_char_q;
  assign bus.rd_in_grid = rd_in_grid_q;
endmodule
